// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus arbiter.
package rtc_bus_pkg;

  localparam int DEFAULT_PHASE_CYCLES = 74;

  // Requester identifiers, in descending grant priority.
  localparam logic [1:0] ID_INIT = 2'd0;
  localparam logic [1:0] ID_WR   = 2'd1;
  localparam logic [1:0] ID_RD   = 2'd2;

  // One bus transaction: address phase (A_*) then data phase (D_*),
  // each split into setup / strobe / hold, followed by a one-cycle DONE.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    A_SETUP  = 3'd1,
    A_STROBE = 3'd2,
    A_HOLD   = 3'd3,
    D_SETUP  = 3'd4,
    D_STROBE = 3'd5,
    D_HOLD   = 3'd6,
    DONE     = 3'd7
  } state_e;

  // Successor of a timed sub-phase once its timer expires.
  function automatic state_e next_phase(input state_e s);
    case (s)
      A_SETUP:  return A_STROBE;
      A_STROBE: return A_HOLD;
      A_HOLD:   return D_SETUP;
      D_SETUP:  return D_STROBE;
      D_STROBE: return D_HOLD;
      D_HOLD:   return DONE;
      default:  return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Sub-phase timer: counts 1..PHASE_CYCLES and flags the last cycle.
module rtc_phase_timer #(
  parameter int CNT_W        = 12,
  parameter int PHASE_CYCLES = 74
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: park at 1 while cleared, wrap to 1 after the last cycle.
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    if (clear_i || (cnt_q == CNT_LAST)) begin
      cnt_d = CNT_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= CNT_ONE;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Fixed-priority arbiter and timed transaction engine for the RTC
// multiplexed address/data bus. Priority: init, then write, then read.
// Requests are levels sampled only in IDLE; the winner's address, data
// and direction are latched at the grant edge and the transaction runs
// to completion regardless of later request or operand changes.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYCLES = DEFAULT_PHASE_CYCLES,
  parameter int CNT_W        = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_req,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_data,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic       init_done,
  output logic       wr_done,
  output logic       rd_done,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output state_e     dbg_state_o
);

  state_e     state_q, state_d;
  logic [1:0] id_q, id_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       wr_q, wr_d;          // 1 = write transaction, 0 = read

  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       ad_sel_q, ad_sel_d;
  logic       ad_oe_q, ad_oe_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       busy_q, busy_d;
  logic       init_done_q, init_done_d;
  logic       wr_done_q, wr_done_d;
  logic       rd_done_q, rd_done_d;

  logic       timer_clear;
  logic       phase_expire;

  // The timer only runs inside the six timed sub-phases.
  assign timer_clear = (state_q == IDLE) || (state_q == DONE);

  rtc_phase_timer #(
    .CNT_W        (CNT_W),
    .PHASE_CYCLES (PHASE_CYCLES)
  ) u_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .clear_i  (timer_clear),
    .expire_o (phase_expire)
  );

  // Next state: grant in IDLE, step through sub-phases on timer expiry.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (init_req) begin
          state_d = A_SETUP;
          id_d    = ID_INIT;
          addr_d  = init_addr;
          data_d  = init_data;
          wr_d    = 1'b1;
        end else if (wr_req) begin
          state_d = A_SETUP;
          id_d    = ID_WR;
          addr_d  = wr_addr;
          data_d  = wr_data;
          wr_d    = 1'b1;
        end else if (rd_req) begin
          state_d = A_SETUP;
          id_d    = ID_RD;
          addr_d  = rd_addr;
          wr_d    = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        if (phase_expire) begin
          state_d = next_phase(state_q);
        end
      end
    endcase
  end

  // Pin values for the coming cycle, derived from the next state so that
  // every output leaves a flop aligned with its state.
  always_comb begin
    cs_n_d      = 1'b1;
    rd_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    ad_sel_d    = 1'b0;
    ad_oe_d     = 1'b0;
    ad_out_d    = 8'h00;
    busy_d      = (state_d != IDLE);
    init_done_d = 1'b0;
    wr_done_d   = 1'b0;
    rd_done_d   = 1'b0;
    rd_data_d   = rd_data_q;
    // Capture the RTC's read byte on the final strobe cycle.
    if ((state_q == D_STROBE) && phase_expire && !wr_q) begin
      rd_data_d = ad_in;
    end
    case (state_d)
      A_SETUP, A_STROBE, A_HOLD: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b1;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        wr_n_d   = (state_d != A_STROBE);
      end
      D_SETUP, D_STROBE, D_HOLD: begin
        cs_n_d = 1'b0;
        if (wr_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = data_d;
          wr_n_d   = (state_d != D_STROBE);
        end else begin
          rd_n_d   = (state_d != D_STROBE);
        end
      end
      DONE: begin
        init_done_d = (id_d == ID_INIT);
        wr_done_d   = (id_d == ID_WR);
        rd_done_d   = (id_d == ID_RD);
      end
      default: begin
      end
    endcase
  end

  // State, latched operands and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      id_q        <= ID_INIT;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      wr_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      ad_sel_q    <= 1'b0;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= 8'h00;
      rd_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      ad_sel_q    <= ad_sel_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
    end
  end

  assign cs_n        = cs_n_q;
  assign rd_n        = rd_n_q;
  assign wr_n        = wr_n_q;
  assign ad_sel      = ad_sel_q;
  assign ad_oe       = ad_oe_q;
  assign ad_out      = ad_out_q;
  assign rd_data     = rd_data_q;
  assign busy        = busy_q;
  assign init_done   = init_done_q;
  assign wr_done     = wr_done_q;
  assign rd_done     = rd_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: two instances (PHASE_CYCLES=4 and =1) share
// one stimulus stream; every cycle both are compared with a transaction
// model that predicts pins from the cycle offset since the grant edge.
module tb_rtc_bus_arbiter;
  import rtc_bus_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       init_req, wr_req, rd_req;
  logic [7:0] init_addr, init_data, wr_addr, wr_data, rd_addr, ad_in;

  logic [1:0] init_done_w, wr_done_w, rd_done_w, busy_w;
  logic [1:0] cs_n_w, rd_n_w, wr_n_w, ad_sel_w, ad_oe_w;
  logic [7:0] rd_data_w [2];
  logic [7:0] ad_out_w [2];
  state_e     dbg_state_w [2];

  rtc_bus_arbiter #(.PHASE_CYCLES(4), .CNT_W(12)) dut0 (
    .clk(clk), .reset(reset),
    .init_req(init_req), .init_addr(init_addr), .init_data(init_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .init_done(init_done_w[0]), .wr_done(wr_done_w[0]), .rd_done(rd_done_w[0]),
    .rd_data(rd_data_w[0]), .busy(busy_w[0]),
    .cs_n(cs_n_w[0]), .rd_n(rd_n_w[0]), .wr_n(wr_n_w[0]),
    .ad_sel(ad_sel_w[0]), .ad_out(ad_out_w[0]), .ad_oe(ad_oe_w[0]),
    .ad_in(ad_in), .dbg_state_o(dbg_state_w[0])
  );

  rtc_bus_arbiter #(.PHASE_CYCLES(1), .CNT_W(12)) dut1 (
    .clk(clk), .reset(reset),
    .init_req(init_req), .init_addr(init_addr), .init_data(init_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .init_done(init_done_w[1]), .wr_done(wr_done_w[1]), .rd_done(rd_done_w[1]),
    .rd_data(rd_data_w[1]), .busy(busy_w[1]),
    .cs_n(cs_n_w[1]), .rd_n(rd_n_w[1]), .wr_n(wr_n_w[1]),
    .ad_sel(ad_sel_w[1]), .ad_out(ad_out_w[1]), .ad_oe(ad_oe_w[1]),
    .ad_in(ad_in), .dbg_state_o(dbg_state_w[1])
  );

  // ---------------- reference model ----------------
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         m_p [2] = '{4, 1};
  bit         m_active [2];
  int         m_t [2];
  logic [1:0] m_id [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_data [2];
  bit         m_wr [2];
  logic [7:0] m_rd [2];
  logic [1:0] exp_q [$];        // grant order expected on dut0's done pulses
  logic [1:0] order_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_active[i] = 0;
        m_t[i]      = 0;
        m_rd[i]     = 8'h00;
        if (i == 0) exp_q.delete();
      end else if (m_active[i]) begin
        if (!m_wr[i] && (m_t[i] == 5 * m_p[i] - 1)) m_rd[i] = ad_in;
        m_t[i]++;
        if (m_t[i] > 6 * m_p[i]) m_active[i] = 0;
      end else if (init_req || wr_req || rd_req) begin
        m_active[i] = 1;
        m_t[i]      = 0;
        if (init_req) begin
          m_id[i] = ID_INIT; m_addr[i] = init_addr; m_data[i] = init_data; m_wr[i] = 1;
        end else if (wr_req) begin
          m_id[i] = ID_WR; m_addr[i] = wr_addr; m_data[i] = wr_data; m_wr[i] = 1;
        end else begin
          m_id[i] = ID_RD; m_addr[i] = rd_addr; m_wr[i] = 0;
        end
        if (i == 0) exp_q.push_back(m_id[0]);
      end
    end
  endtask

  // Compare both instances with the model's prediction for this cycle.
  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      logic       e_cs, e_rd, e_wr, e_oe, e_sel, e_busy;
      logic [7:0] e_out;
      logic [2:0] e_done;
      bit         sel_known;
      int         ph;
      e_cs = 1; e_rd = 1; e_wr = 1; e_oe = 0; e_sel = 0; e_busy = 0;
      e_out = 8'h00; e_done = 3'b000; sel_known = 0; ph = 0;
      if (m_active[i]) begin
        e_busy = 1;
        if (m_t[i] < 6 * m_p[i]) begin
          ph = m_t[i] / m_p[i];
          e_cs = 0; sel_known = 1; e_sel = (ph < 3);
          if (ph < 3) begin
            e_oe = 1; e_out = m_addr[i];
            if (ph == 1) e_wr = 0;
          end else begin
            e_oe = m_wr[i]; e_out = m_data[i];
            if (ph == 4) begin
              if (m_wr[i]) e_wr = 0;
              else e_rd = 0;
            end
          end
        end else begin
          e_done = (m_id[i] == ID_INIT) ? 3'b100 : (m_id[i] == ID_WR) ? 3'b010 : 3'b001;
        end
      end
      chk($sformatf("cs_n[%0d]", i), cs_n_w[i], e_cs);
      chk($sformatf("rd_n[%0d]", i), rd_n_w[i], e_rd);
      chk($sformatf("wr_n[%0d]", i), wr_n_w[i], e_wr);
      chk($sformatf("ad_oe[%0d]", i), ad_oe_w[i], e_oe);
      chk($sformatf("busy[%0d]", i), busy_w[i], e_busy);
      chk($sformatf("done[%0d]", i), {init_done_w[i], wr_done_w[i], rd_done_w[i]}, e_done);
      chk($sformatf("rd_data[%0d]", i), rd_data_w[i], m_rd[i]);
      if (sel_known) chk($sformatf("ad_sel[%0d]", i), ad_sel_w[i], e_sel);
      if (e_oe) chk($sformatf("ad_out[%0d]", i), ad_out_w[i], e_out);
    end
    // Scoreboard: dut0's done pulses must follow the model's grant order.
    if (init_done_w[0] || wr_done_w[0] || rd_done_w[0]) begin
      logic [1:0] obs_id;
      obs_id = init_done_w[0] ? ID_INIT : (wr_done_w[0] ? ID_WR : ID_RD);
      order_q.push_back(obs_id);
      if (exp_q.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
      else chk("sb_done_order", obs_id, exp_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n_done0, n_done1, n_low0, n_low1, g0, lat0, lat1, busy_cnt;
    bit drop_i, drop_w, drop_r;

    reset = 1; init_req = 0; wr_req = 0; rd_req = 0;
    init_addr = 0; init_data = 0; wr_addr = 0; wr_data = 0; rd_addr = 0; ad_in = 0;
    ticks(3);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_state[%0d]", i), dbg_state_w[i], IDLE);
      chk($sformatf("rst_ad_out[%0d]", i), ad_out_w[i], 8'h00);
      chk($sformatf("rst_ad_sel[%0d]", i), ad_sel_w[i], 1'b0);
    end
    reset = 0;
    ticks(2);

    // Write 0x15 to 0x21; request dropped and operands changed after grant.
    wr_req = 1; wr_addr = 8'h21; wr_data = 8'h15;
    g0 = cyc + 1;
    tick();
    wr_req = 0; wr_addr = 8'h99; wr_data = 8'hAA;
    n_done0 = 0; n_done1 = 0; n_low0 = 0; n_low1 = 0; lat0 = -1; lat1 = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_low0 += int'(!wr_n_w[0]);
      n_low1 += int'(!wr_n_w[1]);
      if (wr_done_w[0]) begin n_done0++; lat0 = cyc - g0; end
      if (wr_done_w[1]) begin n_done1++; lat1 = cyc - g0; end
    end
    chk("wr_done_count_p4", n_done0, 1);
    chk("wr_done_count_p1", n_done1, 1);
    chk("wr_done_latency_p4", lat0, 24);
    chk("wr_done_latency_p1", lat1, 6);
    chk("wr_n_low_cycles_p4", n_low0, 8);
    chk("wr_n_low_cycles_p1", n_low1, 2);

    // Read from 0x41 with the RTC returning 0x37.
    rd_req = 1; rd_addr = 8'h41; ad_in = 8'h37;
    tick();
    rd_req = 0; rd_addr = 8'h00;
    n_done0 = 0; n_low0 = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_low0 += int'(!rd_n_w[0]);
      n_done0 += int'(rd_done_w[0]);
    end
    ad_in = 8'h00;
    tick();
    chk("rd_n_low_cycles_p4", n_low0, 4);
    chk("rd_done_count_p4", n_done0, 1);
    chk("rd_data_held_p4", rd_data_w[0], 8'h37);
    chk("rd_data_held_p1", rd_data_w[1], 8'h37);

    // All three requesters at once, each held until its own done.
    order_q.delete();
    init_req = 1; init_addr = 8'h0F; init_data = 8'h80;
    wr_req = 1; wr_addr = 8'h22; wr_data = 8'h5C;
    rd_req = 1; rd_addr = 8'h43; ad_in = 8'hC3;
    drop_i = 0; drop_w = 0; drop_r = 0;
    for (int k = 0; k < 200 && !(drop_i && drop_w && drop_r); k++) begin
      tick();
      if (init_done_w[0]) begin init_req = 0; drop_i = 1; end
      if (wr_done_w[0])   begin wr_req = 0;   drop_w = 1; end
      if (rd_done_w[0])   begin rd_req = 0;   drop_r = 1; end
    end
    chk("prio_done_count", order_q.size(), 3);
    if (order_q.size() == 3) begin
      chk("prio_first_init", order_q[0], ID_INIT);
      chk("prio_second_wr", order_q[1], ID_WR);
      chk("prio_third_rd", order_q[2], ID_RD);
    end
    ticks(10);

    // Reset in the data strobe of a write, then a fresh full write.
    wr_req = 1; wr_addr = 8'h33; wr_data = 8'h5A;
    tick();
    wr_req = 0;
    ticks(16);
    chk("pre_reset_in_d_strobe", wr_n_w[0], 1'b0);
    reset = 1;
    tick();
    chk("rst_mid_cs_n", cs_n_w[0], 1'b1);
    chk("rst_mid_wr_n", wr_n_w[0], 1'b1);
    chk("rst_mid_ad_oe", ad_oe_w[0], 1'b0);
    chk("rst_mid_busy", busy_w[0], 1'b0);
    chk("rst_mid_wr_done", wr_done_w[0], 1'b0);
    reset = 0;
    tick();
    wr_req = 1; wr_addr = 8'h34; wr_data = 8'hA5;
    tick();
    wr_req = 0;
    n_done0 = 0; busy_cnt = 1;
    for (int k = 0; k < 30; k++) begin
      tick();
      busy_cnt += int'(busy_w[0]);
      n_done0 += int'(wr_done_w[0]);
    end
    chk("post_reset_busy_cycles", busy_cnt, 25);
    chk("post_reset_wr_done", n_done0, 1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      init_req  = ($urandom_range(0, 15) == 0);
      wr_req    = ($urandom_range(0, 5) == 0);
      rd_req    = ($urandom_range(0, 3) == 0);
      init_addr = 8'($urandom); init_data = 8'($urandom);
      wr_addr   = 8'($urandom); wr_data   = 8'($urandom);
      rd_addr   = 8'($urandom); ad_in     = 8'($urandom);
      reset     = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 0; init_req = 0; wr_req = 0; rd_req = 0;
    ticks(30);
    chk("final_sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
